pressure_cycle_ctrl: RTL and testbench
======================================

PRESSURE_CYCLE_CTRL -- requirements
Module: pressure_cycle_ctrl

Interface
REQ-001 Parameter RISE_TIMEOUT, default 16'd64, the maximum en ticks allowed in PRESSURIZE before a leak fault.
REQ-002 Parameter VENT_SAFE, default 16'd256, the pressure threshold below which the vessel is safe to open.
REQ-003 clk  in  1  the single clock; all state updates occur on its rising edge.
REQ-004 rst_n  in  1  the reset, asynchronous and active-low.
REQ-005 en  in  1  the process tick; counters advance only on cycles where en=1.
REQ-006 start  in  1  requests one cycle; honoured in IDLE only.
REQ-007 abort  in  1  requests an early, orderly vent.
REQ-008 fault_clr  in  1  acknowledges a fault.
REQ-009 hold_ticks  in  16  the hold duration in en ticks, sampled at start.
REQ-010 S_pressure  in  16  the vessel pressure, unsigned.
REQ-011 S_pressure_low, S_pressure_high  in  1 each  the pressure band flags.
REQ-012 S_cover_closed, S_cover_opened, S_cover_leaky  in  1 each  the cover status.
REQ-013 X_pressurize  out  1  the compressor command.
REQ-014 X_cover_lock  out  1  the cover latch command.
REQ-015 busy  out  1  high in every state other than IDLE.
REQ-016 done  out  1  a one-clk pulse on cycle completion.
REQ-017 fault  out  1  high in FAULT.
REQ-018 fault_code  out  2  the sticky fault reason.
REQ-019 state  out  3  the current state encoding, for debug.

Function
REQ-020 The state set SHALL be IDLE, PRESSURIZE, HOLD, VENT, DONE, FAULT, with all transitions evaluated every clk and counters decremented or incremented only when en=1.
REQ-021 In IDLE, start with S_cover_closed=1 SHALL load hold_cnt=hold_ticks, clear rise_cnt to 0, and go to PRESSURIZE.
REQ-022 In IDLE, start with S_cover_closed=0 SHALL go to FAULT with fault_code=NOT_CLOSED (0).
REQ-023 In PRESSURIZE, the block SHALL drive X_pressurize=1 and X_cover_lock=1, and increment rise_cnt (saturating) on each en.
REQ-024 In PRESSURIZE, S_pressure_high SHALL cause a transition to HOLD.
REQ-025 In PRESSURIZE, rise_cnt==RISE_TIMEOUT with S_pressure_high=0 SHALL go to FAULT with fault_code=LEAK (1); high wins if both are true in the same cycle.
REQ-026 In HOLD, X_pressurize SHALL equal !S_pressure_high (combinational band regulation), X_cover_lock SHALL be 1, and hold_cnt SHALL decrement on en.
REQ-027 In HOLD, the block SHALL go to VENT on the clk where hold_cnt==0, including immediately when hold_ticks=0.
REQ-028 In HOLD, S_pressure_low SHALL go to FAULT with fault_code=DROP (2).
REQ-029 In VENT, the block SHALL drive X_pressurize=0 and X_cover_lock=1, and go to DONE when S_pressure<VENT_SAFE.
REQ-030 DONE SHALL last exactly one clk with done=1 and X_cover_lock=0, then go to IDLE.
REQ-031 In FAULT, the block SHALL drive X_pressurize=0 and set X_cover_lock=(S_pressure>=VENT_SAFE).
REQ-032 In FAULT, fault_clr with S_pressure<VENT_SAFE SHALL go to IDLE; fault_clr while pressure is unsafe SHALL be ignored.
REQ-033 fault_code SHALL persist until the next fault or reset.
REQ-034 S_cover_opened in PRESSURIZE, HOLD or VENT SHALL go to FAULT with fault_code=COVER (3).
REQ-035 abort in PRESSURIZE or HOLD SHALL go to VENT without a fault; abort SHALL be ignored in all other states.
REQ-036 Priority per cycle SHALL be: cover opened > abort > fault conditions > normal progression.
REQ-037 start while busy SHALL be ignored; hold_ticks changes after start SHALL have no effect.
REQ-038 In IDLE, X_pressurize and X_cover_lock SHALL be 0; S_cover_leaky SHALL be informational only and SHALL NOT change any transition.

Reset
REQ-039 rst_n=0 SHALL asynchronously force state=IDLE, hold_cnt=0, rise_cnt=0, fault_code=0, and all outputs 0.
REQ-040 Reset asserted mid-cycle SHALL abandon the cycle with no done pulse.

Structure
REQ-041 Package pressure_pkg SHALL hold the state enum, the fault_code enum (NOT_CLOSED, LEAK, DROP, COVER), and the RISE_TIMEOUT and VENT_SAFE defaults.
REQ-042 One sub-module, tick_counter (16-bit load/decrement on en, zero flag), SHALL implement hold_cnt.
REQ-043 rise_cnt SHALL be inline.

Verification
REQ-044 Cover closed, start, hold_ticks=5, pressure rising to high at tick 10 -> HOLD for 5 en ticks, VENT, then done pulse once S_pressure<256.
REQ-045 Cover leaky, pressure stuck below high -> FAULT with fault_code=1 after 64 en ticks; fault_clr accepted only after S_pressure<256.
REQ-046 S_cover_opened during HOLD with a simultaneous abort -> FAULT with fault_code=3, not VENT.
REQ-047 start with S_cover_closed=0 -> FAULT with fault_code=0 next clk and X_pressurize never asserted.
REQ-048 hold_ticks=0 -> HOLD lasts one clk; rst_n low during VENT -> immediate IDLE with all outputs 0 and no done pulse.

Source files
------------

// File: rtl/pressure_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : pressure_pkg
//  Purpose  : Shared types and defaults for the pressure cycle controller:
//             FSM state encoding, sticky fault reasons, and the default
//             rise timeout / vent-safe threshold.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package pressure_pkg;

  // Encodings are exported on the debug 'state' port; keep them stable.
  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    PRESSURIZE = 3'd1,
    HOLD       = 3'd2,
    VENT       = 3'd3,
    DONE       = 3'd4,
    FAULT      = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    NOT_CLOSED = 2'd0,
    LEAK       = 2'd1,
    DROP       = 2'd2,
    COVER      = 2'd3
  } fault_t;

  localparam logic [15:0] DEF_RISE_TIMEOUT = 16'd64;
  localparam logic [15:0] DEF_VENT_SAFE    = 16'd256;

endpackage
`default_nettype wire

// File: rtl/tick_counter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tick_counter
//  Purpose  : Loadable down-counter that steps only on process ticks and
//             stops at zero. Used for the HOLD duration.
//  Ports    : clk, rst_n (async, active-low)
//             en       - process tick
//             load     - load load_val (takes precedence over decrement)
//             dec      - decrement allowed this cycle (gated with en)
//             load_val - value to load
//             zero     - count is zero
//  Revision : 1.0 - initial release
// ============================================================================
module tick_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic             dec,
  input  logic [WIDTH-1:0] load_val,
  output logic             zero
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (dec && en && (r_count != '0)) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

  assign zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/pressure_cycle_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : pressure_cycle_ctrl
//  Purpose  : Sequences one pressure cycle: pressurize to the high band,
//             hold for a tick count, vent below the safe threshold, then
//             release the cover. Faults (cover not closed, leak, pressure
//             drop, cover opened) are latched with a sticky reason code.
//  Ports    : clk, rst_n (async, active-low), en (process tick)
//             start, abort, fault_clr, hold_ticks[15:0]
//             S_pressure[15:0], S_pressure_low/high, S_cover_closed/
//             opened/leaky
//             X_pressurize, X_cover_lock, busy, done, fault,
//             fault_code[1:0], state[2:0]
//  Revision : 1.0 - initial release
// ============================================================================
module pressure_cycle_ctrl
  import pressure_pkg::*;
#(
  parameter logic [15:0] RISE_TIMEOUT = DEF_RISE_TIMEOUT,
  parameter logic [15:0] VENT_SAFE    = DEF_VENT_SAFE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        start,
  input  logic        abort,
  input  logic        fault_clr,
  input  logic [15:0] hold_ticks,
  input  logic [15:0] S_pressure,
  input  logic        S_pressure_low,
  input  logic        S_pressure_high,
  input  logic        S_cover_closed,
  input  logic        S_cover_opened,
  input  logic        S_cover_leaky,
  output logic        X_pressurize,
  output logic        X_cover_lock,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic [1:0]  fault_code,
  output logic [2:0]  state
);

  state_t      r_state;
  fault_t      r_fault_code;
  logic [15:0] r_rise_cnt;
  logic        w_hold_zero;
  logic        w_hold_load;
  logic        w_safe;

  // Leak status is reported by the plant but never steers the sequence.
  logic unused_cover_leaky;
  assign unused_cover_leaky = S_cover_leaky;

  assign w_safe      = (S_pressure < VENT_SAFE);
  // hold_ticks is captured only when a cycle is actually accepted.
  assign w_hold_load = (r_state == IDLE) && start && S_cover_closed;

  tick_counter #(
    .WIDTH (16)
  ) u_hold_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .load     (w_hold_load),
    .dec      (r_state == HOLD),
    .load_val (hold_ticks),
    .zero     (w_hold_zero)
  );

  // Within each active state the branch order encodes priority:
  // cover opened, then abort, then fault conditions, then progression.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_fault_code <= NOT_CLOSED;
      r_rise_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            if (S_cover_closed) begin
              r_rise_cnt <= '0;
              r_state    <= PRESSURIZE;
            end else begin
              r_fault_code <= NOT_CLOSED;
              r_state      <= FAULT;
            end
          end
        end

        PRESSURIZE: begin
          if (en && (r_rise_cnt != 16'hFFFF)) begin
            r_rise_cnt <= r_rise_cnt + 16'd1;
          end
          if (S_cover_opened) begin
            r_fault_code <= COVER;
            r_state      <= FAULT;
          end else if (abort) begin
            r_state <= VENT;
          end else if (S_pressure_high) begin
            // Reaching the band wins over a coincident timeout.
            r_state <= HOLD;
          end else if (r_rise_cnt == RISE_TIMEOUT) begin
            r_fault_code <= LEAK;
            r_state      <= FAULT;
          end
        end

        HOLD: begin
          if (S_cover_opened) begin
            r_fault_code <= COVER;
            r_state      <= FAULT;
          end else if (abort) begin
            r_state <= VENT;
          end else if (S_pressure_low) begin
            r_fault_code <= DROP;
            r_state      <= FAULT;
          end else if (w_hold_zero) begin
            r_state <= VENT;
          end
        end

        VENT: begin
          if (S_cover_opened) begin
            r_fault_code <= COVER;
            r_state      <= FAULT;
          end else if (w_safe) begin
            r_state <= DONE;
          end
        end

        DONE: begin
          r_state <= IDLE;
        end

        FAULT: begin
          if (fault_clr && w_safe) begin
            r_state <= IDLE;
          end
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Outputs decode the registered state; HOLD regulates the compressor
  // directly off the high flag, and FAULT keeps the cover latched while
  // the vessel is still pressurised.
  always_comb begin
    X_pressurize = 1'b0;
    X_cover_lock = 1'b0;
    case (r_state)
      PRESSURIZE: begin
        X_pressurize = 1'b1;
        X_cover_lock = 1'b1;
      end
      HOLD: begin
        X_pressurize = !S_pressure_high;
        X_cover_lock = 1'b1;
      end
      VENT: begin
        X_cover_lock = 1'b1;
      end
      FAULT: begin
        X_cover_lock = !w_safe;
      end
      default: begin
        X_pressurize = 1'b0;
        X_cover_lock = 1'b0;
      end
    endcase
  end

  assign busy       = (r_state != IDLE);
  assign done       = (r_state == DONE);
  assign fault      = (r_state == FAULT);
  assign fault_code = r_fault_code;
  assign state      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_pressure_cycle_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_pressure_cycle_ctrl
//  Purpose  : Directed self-checking bench for pressure_cycle_ctrl.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pressure_cycle_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        start;
  logic        abort;
  logic        fault_clr;
  logic [15:0] hold_ticks;
  logic [15:0] S_pressure;
  logic        S_pressure_low;
  logic        S_pressure_high;
  logic        S_cover_closed;
  logic        S_cover_opened;
  logic        S_cover_leaky;
  logic        X_pressurize;
  logic        X_cover_lock;
  logic        busy;
  logic        done;
  logic        fault;
  logic [1:0]  fault_code;
  logic [2:0]  state;

  int n_total = 0;
  int n_pass  = 0;
  int done_cnt  = 0;
  int press_cnt = 0;
  int snap_done;
  int snap_press;

  localparam int ST_IDLE = 0, ST_PRESS = 1, ST_HOLD = 2, ST_VENT = 3,
                 ST_DONE = 4, ST_FAULT = 5;

  pressure_cycle_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .en              (en),
    .start           (start),
    .abort           (abort),
    .fault_clr       (fault_clr),
    .hold_ticks      (hold_ticks),
    .S_pressure      (S_pressure),
    .S_pressure_low  (S_pressure_low),
    .S_pressure_high (S_pressure_high),
    .S_cover_closed  (S_cover_closed),
    .S_cover_opened  (S_cover_opened),
    .S_cover_leaky   (S_cover_leaky),
    .X_pressurize    (X_pressurize),
    .X_cover_lock    (X_cover_lock),
    .busy            (busy),
    .done            (done),
    .fault           (fault),
    .fault_code      (fault_code),
    .state           (state)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (X_pressurize === 1'b1) press_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; start = 1'b0; abort = 1'b0; fault_clr = 1'b0;
    hold_ticks = 16'd0; S_pressure = 16'd0; S_pressure_low = 1'b0;
    S_pressure_high = 1'b0; S_cover_closed = 1'b0; S_cover_opened = 1'b0;
    S_cover_leaky = 1'b0;
    step(); step();
    chk("rst_state", 32'(state), ST_IDLE);
    chk("rst_press", 32'(X_pressurize), 0);
    chk("rst_lock", 32'(X_cover_lock), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_code", 32'(fault_code), 0);
    rst_n = 1'b1;
    step();

    // ---- Nominal cycle: hold 5 ticks, high reached on tick 10 ----
    en = 1'b1; S_cover_closed = 1'b1; hold_ticks = 16'd5; S_pressure = 16'd100;
    start = 1'b1;
    step();
    start = 1'b0; hold_ticks = 16'd9;
    chk("a_press_state", 32'(state), ST_PRESS);
    chk("a_press_out", 32'(X_pressurize), 1);
    chk("a_press_lock", 32'(X_cover_lock), 1);
    chk("a_busy", 32'(busy), 1);
    for (int i = 0; i < 9; i++) begin
      S_pressure = S_pressure + 16'd150;
      step();
    end
    chk("a_still_press", 32'(state), ST_PRESS);
    S_pressure = 16'd2000; S_pressure_high = 1'b1;
    step();
    chk("a_hold_state", 32'(state), ST_HOLD);
    chk("a_hold_reg_hi", 32'(X_pressurize), 0);
    S_pressure_high = 1'b0; #1;
    chk("a_hold_reg_lo", 32'(X_pressurize), 1);
    S_pressure_high = 1'b1;
    // No ticks and a stray start: nothing must move.
    en = 1'b0; start = 1'b1;
    repeat (3) step();
    start = 1'b0; en = 1'b1;
    chk("a_hold_noen", 32'(state), ST_HOLD);
    repeat (5) step();
    chk("a_hold_5", 32'(state), ST_HOLD);
    step();
    chk("a_vent_state", 32'(state), ST_VENT);
    chk("a_vent_press", 32'(X_pressurize), 0);
    chk("a_vent_lock", 32'(X_cover_lock), 1);
    S_pressure_high = 1'b0;
    step();
    chk("a_vent_unsafe", 32'(state), ST_VENT);
    S_pressure = 16'd255;
    step();
    chk("a_done_state", 32'(state), ST_DONE);
    chk("a_done_pulse", 32'(done), 1);
    chk("a_done_lock", 32'(X_cover_lock), 0);
    step();
    chk("a_idle_state", 32'(state), ST_IDLE);
    chk("a_idle_done", 32'(done), 0);
    chk("a_done_count", 32'(done_cnt), 1);

    // ---- Start with cover open: immediate fault, no compressor ----
    snap_press = press_cnt;
    S_cover_closed = 1'b0; S_pressure = 16'd100; start = 1'b1;
    step();
    start = 1'b0;
    chk("d_state", 32'(state), ST_FAULT);
    chk("d_code", 32'(fault_code), 0);
    chk("d_fault", 32'(fault), 1);
    step();
    chk("d_no_press", 32'(press_cnt - snap_press), 0);
    fault_clr = 1'b1;
    step();
    fault_clr = 1'b0;
    chk("d_clr", 32'(state), ST_IDLE);

    // ---- Leaky cover, pressure never reaches high: leak after 64 ticks ----
    S_cover_closed = 1'b1; S_cover_leaky = 1'b1; S_pressure = 16'd300; start = 1'b1;
    step();
    start = 1'b0;
    repeat (64) step();
    chk("b_press_64", 32'(state), ST_PRESS);
    step();
    chk("b_fault_state", 32'(state), ST_FAULT);
    chk("b_code", 32'(fault_code), 1);
    chk("b_press_off", 32'(X_pressurize), 0);
    chk("b_lock_unsafe", 32'(X_cover_lock), 1);
    fault_clr = 1'b1;
    step();
    chk("b_clr_ignored", 32'(state), ST_FAULT);
    S_pressure = 16'd200; #1;
    chk("b_lock_safe", 32'(X_cover_lock), 0);
    step();
    fault_clr = 1'b0;
    chk("b_clr_ok", 32'(state), ST_IDLE);
    chk("b_code_sticky", 32'(fault_code), 1);
    S_cover_leaky = 1'b0;

    // ---- Cover opened + abort in HOLD: cover wins ----
    hold_ticks = 16'd5; start = 1'b1;
    step();
    start = 1'b0; S_pressure_high = 1'b1; S_pressure = 16'd2000;
    step();
    chk("c_hold", 32'(state), ST_HOLD);
    S_cover_opened = 1'b1; abort = 1'b1;
    step();
    S_cover_opened = 1'b0; abort = 1'b0; S_pressure_high = 1'b0;
    chk("c_fault", 32'(state), ST_FAULT);
    chk("c_code", 32'(fault_code), 3);
    S_pressure = 16'd100; fault_clr = 1'b1;
    step();
    fault_clr = 1'b0;
    // Abort alone in PRESSURIZE vents without touching the fault code.
    start = 1'b1;
    step();
    start = 1'b0; abort = 1'b1;
    step();
    abort = 1'b0;
    chk("c_abort_vent", 32'(state), ST_VENT);
    chk("c_abort_code", 32'(fault_code), 3);
    step();
    chk("c_abort_done", 32'(state), ST_DONE);
    step();
    // Pressure drop during HOLD.
    start = 1'b1;
    step();
    start = 1'b0; S_pressure_high = 1'b1; S_pressure = 16'd2000;
    step();
    S_pressure_high = 1'b0; S_pressure_low = 1'b1;
    step();
    S_pressure_low = 1'b0;
    chk("c_drop", 32'(state), ST_FAULT);
    chk("c_drop_code", 32'(fault_code), 2);
    S_pressure = 16'd100; fault_clr = 1'b1;
    step();
    fault_clr = 1'b0;

    // ---- hold_ticks=0, then reset during VENT ----
    hold_ticks = 16'd0; start = 1'b1;
    step();
    start = 1'b0; S_pressure_high = 1'b1; S_pressure = 16'd1000;
    step();
    chk("e_hold", 32'(state), ST_HOLD);
    step();
    chk("e_vent_1clk", 32'(state), ST_VENT);
    snap_done = done_cnt;
    rst_n = 1'b0; #1;
    chk("e_rst_state", 32'(state), ST_IDLE);
    chk("e_rst_lock", 32'(X_cover_lock), 0);
    chk("e_rst_press", 32'(X_pressurize), 0);
    chk("e_rst_busy", 32'(busy), 0);
    chk("e_rst_code", 32'(fault_code), 0);
    S_pressure_high = 1'b0; S_pressure = 16'd100;
    step(); step();
    rst_n = 1'b1;
    step(); step();
    chk("e_no_done", 32'(done_cnt - snap_done), 0);
    chk("e_idle_after", 32'(state), ST_IDLE);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
